// File: rtl/count_mon_pkg.sv
// rtl/count_mon_pkg.sv - shared event codes, direction states and FIFO entry type
package count_mon_pkg;

  typedef enum logic [2:0] {
    EVT_NONE     = 3'd0,
    EVT_WRAP_UP  = 3'd1,
    EVT_WRAP_DN  = 3'd2,
    EVT_DIR_UP   = 3'd3,
    EVT_DIR_DN   = 3'd4,
    EVT_CROSS_HI = 3'd5,
    EVT_CROSS_LO = 3'd6,
    EVT_JUMP     = 3'd7
  } evt_code_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } dir_t;

  // Entry carries the widest supported count; the FIFO stores only code + W bits.
  localparam int CNT_MAX_W = 64;

  typedef struct packed {
    evt_code_t              code;
    logic [CNT_MAX_W-1:0]   count;
  } evt_entry_t;

endpackage

// File: rtl/count_event_monitor_if.sv
// rtl/count_event_monitor_if.sv - event stream handshake between monitor and consumer
interface count_event_monitor_if
  import count_mon_pkg::*;
#(
  parameter int W = 32
);
  logic           evt_valid;
  logic           evt_ready;
  evt_code_t      evt_code;
  logic [W-1:0]   evt_count;

  modport master (output evt_valid, output evt_code, output evt_count, input evt_ready);
  modport slave  (input evt_valid, input evt_code, input evt_count, output evt_ready);
endinterface

// File: rtl/evt_fifo.sv
// rtl/evt_fifo.sv - synchronous event queue with registered valid and drop-on-full
module evt_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 35
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          full,
  output logic          drop
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   occ, occ_next;
  logic          do_push, do_pop;

  // A pop frees the slot the simultaneous push needs, so full+pop still accepts.
  assign full     = (occ == (AW+1)'(DEPTH));
  assign do_pop   = pop && out_valid;
  assign do_push  = push && (!full || do_pop);
  assign drop     = push && !do_push;
  assign occ_next = occ + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign out_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      occ       <= occ_next;
      out_valid <= (occ_next != '0);
    end
  end
endmodule

// File: rtl/count_event_monitor.sv
// rtl/count_event_monitor.sv - detects wraps, direction changes, threshold crossings and jumps on a counter
// Optional COUNT_MON_STATS_EN adds a saturating drop_cnt output.
module count_event_monitor
  import count_mon_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [W-1:0]           count,
  input  logic [W-1:0]           thresh_hi,
  input  logic [W-1:0]           thresh_lo,
  count_event_monitor_if.master  evt,
  output dir_t                   dir,
  output logic                   ovf
`ifdef COUNT_MON_STATS_EN
  ,
  output logic [7:0]             drop_cnt
`endif
);
  logic [W-1:0] prev, d;
  logic         primed;
  logic         up_step, dn_step, jump;
  logic         wrap_up, wrap_dn, cross_hi, cross_lo;
  evt_code_t    code;
  evt_entry_t   ent;
  logic         push, pop, full, drop, head_valid;
  logic [W+2:0] head;
  logic         unused_ent_bits;

  always_comb begin
    d        = count - prev;
    up_step  = (d == W'(1));
    dn_step  = (d == '1);
    jump     = (d != '0) && !up_step && !dn_step;
    wrap_up  = (prev == '1) && (count == '0);
    wrap_dn  = (prev == '0) && (count == '1);
    cross_hi = (prev < thresh_hi) && (count >= thresh_hi);
    cross_lo = (prev > thresh_lo) && (count <= thresh_lo);

    code = EVT_NONE;
    if (jump)                          code = EVT_JUMP;
    else if (wrap_up)                  code = EVT_WRAP_UP;
    else if (wrap_dn)                  code = EVT_WRAP_DN;
    else if (dir == ST_DOWN && up_step) code = EVT_DIR_UP;
    else if (dir == ST_UP && dn_step)   code = EVT_DIR_DN;
    else if (cross_hi)                 code = EVT_CROSS_HI;
    else if (cross_lo)                 code = EVT_CROSS_LO;

    ent.code  = code;
    ent.count = CNT_MAX_W'(count);
  end

  assign unused_ent_bits = ^ent.count;
  assign push = primed && (code != EVT_NONE);
  assign pop  = head_valid && evt.evt_ready;

  // Direction FSM; the first edge after reset only loads prev.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev   <= '0;
      primed <= 1'b0;
      dir    <= ST_IDLE;
    end else begin
      prev   <= count;
      primed <= 1'b1;
      if (primed) begin
        if (jump)         dir <= ST_IDLE;
        else if (up_step) dir <= ST_UP;
        else if (dn_step) dir <= ST_DOWN;
      end
    end
  end

  evt_fifo #(
    .DEPTH (DEPTH),
    .DW    (W + 3)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({ent.code, ent.count[W-1:0]}),
    .pop       (pop),
    .out_valid (head_valid),
    .out_data  (head),
    .full      (full),
    .drop      (drop)
  );

  assign evt.evt_valid = head_valid;
  assign evt.evt_code  = evt_code_t'(head[W+2:W]);
  assign evt.evt_count = head[W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ovf <= 1'b0;
    else if (drop) ovf <= 1'b1;
  end

`ifdef COUNT_MON_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           drop_cnt <= 8'd0;
    else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end
`endif
endmodule

// File: tb/tb_count_event_monitor.sv
// tb/tb_count_event_monitor.sv - directed vector bench for count_event_monitor
module tb_count_event_monitor;
  localparam int W = 32;
  localparam logic [W-1:0] H0 = 32'h8000_0000;
  localparam logic [W-1:0] L0 = 32'h0;
  localparam logic [W-1:0] H1 = 32'd10;
  localparam logic [W-1:0] L1 = 32'd3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] count = '0;
  logic [W-1:0] thresh_hi = H0;
  logic [W-1:0] thresh_lo = L0;
  logic [1:0]   dir;
  logic         ovf;
`ifdef COUNT_MON_STATS_EN
  logic [7:0]   drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  count_event_monitor_if #(.W(W)) evt_if ();

  count_event_monitor #(.W(W), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .count     (count),
    .thresh_hi (thresh_hi),
    .thresh_lo (thresh_lo),
    .evt       (evt_if),
    .dir       (dir),
    .ovf       (ovf)
`ifdef COUNT_MON_STATS_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] cnt;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         v;
    logic [2:0]   code;
    logic [W-1:0] ecnt;
    logic [1:0]   d;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [W-1:0] c, input logic [W-1:0] h, input logic [W-1:0] l,
                     input logic v, input logic [2:0] cd, input logic [W-1:0] ec, input logic [1:0] dd);
    vec_t t;
    t.cnt = c; t.hi = h; t.lo = l; t.v = v; t.code = cd; t.ecnt = ec; t.d = dd;
    vecs.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic head(input string nm, input logic v, input logic [W-1:0] ec);
    chk({nm, "_valid"}, 64'(evt_if.evt_valid), 64'(v));
    if (v) begin
      chk({nm, "_code"}, 64'(evt_if.evt_code), 64'd7);
      chk({nm, "_count"}, 64'(evt_if.evt_count), 64'(ec));
    end
  endtask

  initial begin
    evt_if.evt_ready = 1'b1;

    //  count         hi  lo  v  code ecnt          dir
    add(32'd0,        H0, L0, 0, 3'd0, 32'd0,        2'd0);
    add(32'd1,        H0, L0, 0, 3'd0, 32'd0,        2'd1);
    add(32'd2,        H0, L0, 0, 3'd0, 32'd0,        2'd1);
    add(32'd3,        H0, L0, 0, 3'd0, 32'd0,        2'd1);
    add(32'd5,        H0, L0, 1, 3'd7, 32'd5,        2'd0);
    add(32'd6,        H0, L0, 0, 3'd0, 32'd0,        2'd1);
    add(32'd5,        H0, L0, 1, 3'd4, 32'd5,        2'd2);
    add(32'hFFFFFFFE, H0, L0, 1, 3'd7, 32'hFFFFFFFE, 2'd0);
    add(32'hFFFFFFFF, H0, L0, 0, 3'd0, 32'd0,        2'd1);
    add(32'd0,        H0, L0, 1, 3'd1, 32'd0,        2'd1);
    add(32'd0,        H0, L0, 0, 3'd0, 32'd0,        2'd1);
    add(32'hFFFFFFFF, H0, L0, 1, 3'd2, 32'hFFFFFFFF, 2'd2);
    add(32'd8,        H1, L1, 1, 3'd7, 32'd8,        2'd0);
    add(32'd9,        H1, L1, 0, 3'd0, 32'd0,        2'd1);
    add(32'd10,       H1, L1, 1, 3'd5, 32'd10,       2'd1);
    add(32'd11,       H1, L1, 0, 3'd0, 32'd0,        2'd1);
    add(32'd10,       H1, L1, 1, 3'd4, 32'd10,       2'd2);
    for (int k = 9; k >= 4; k--) add(32'(k), H1, L1, 0, 3'd0, 32'd0, 2'd2);
    add(32'd3,        H1, L1, 1, 3'd6, 32'd3,        2'd2);
    add(32'd2,        H1, L1, 0, 3'd0, 32'd0,        2'd2);
    add(32'd100,      H1, L1, 1, 3'd7, 32'd100,      2'd0);
    add(32'd0,        H1, L1, 1, 3'd7, 32'd0,        2'd0);

    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(evt_if.evt_valid), 64'd0);
    chk("rst_code",  64'(evt_if.evt_code),  64'd0);
    chk("rst_count", 64'(evt_if.evt_count), 64'd0);
    chk("rst_dir",   64'(dir), 64'd0);
    chk("rst_ovf",   64'(ovf), 64'd0);
`ifdef COUNT_MON_STATS_EN
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
`endif
    rst = 1'b0;

    foreach (vecs[i]) begin
      count     = vecs[i].cnt;
      thresh_hi = vecs[i].hi;
      thresh_lo = vecs[i].lo;
      step();
      chk($sformatf("v%0d_valid", i), 64'(evt_if.evt_valid), 64'(vecs[i].v));
      chk($sformatf("v%0d_dir", i), 64'(dir), 64'(vecs[i].d));
      if (vecs[i].v) begin
        chk($sformatf("v%0d_code", i), 64'(evt_if.evt_code), 64'(vecs[i].code));
        chk($sformatf("v%0d_count", i), 64'(evt_if.evt_count), 64'(vecs[i].ecnt));
      end
    end

    // Overflow: six jumps with the consumer stalled, then a push+pop at full.
    count = 32'd0;
    step();
    head("drain", 1'b0, 32'd0);
    evt_if.evt_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      count = 32'(50 + 10 * k);
      step();
      head($sformatf("stall%0d", k), 1'b1, 32'd50);
      chk($sformatf("stall%0d_ovf", k), 64'(ovf), (k >= 4) ? 64'd1 : 64'd0);
    end
`ifdef COUNT_MON_STATS_EN
    chk("drop_cnt", 64'(drop_cnt), 64'd2);
`endif
    evt_if.evt_ready = 1'b1;
    count = 32'd200;
    step();
    head("full_pushpop", 1'b1, 32'd60);
    step();
    head("drain1", 1'b1, 32'd70);
    step();
    head("drain2", 1'b1, 32'd80);
    step();
    head("drain3", 1'b1, 32'd200);
    step();
    head("drain4", 1'b0, 32'd0);
    chk("ovf_sticky", 64'(ovf), 64'd1);

    // Mid-operation asynchronous reset discards the queue and re-primes.
    evt_if.evt_ready = 1'b0;
    count = 32'd300;
    step();
    head("pre_rst", 1'b1, 32'd300);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(evt_if.evt_valid), 64'd0);
    chk("async_rst_ovf",   64'(ovf), 64'd0);
    chk("async_rst_dir",   64'(dir), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    evt_if.evt_ready = 1'b1;
    count = 32'd500;
    step();
    chk("prime_valid", 64'(evt_if.evt_valid), 64'd0);
    chk("prime_dir",   64'(dir), 64'd0);
    count = 32'd501;
    step();
    chk("post_prime_valid", 64'(evt_if.evt_valid), 64'd0);
    chk("post_prime_dir",   64'(dir), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/count_event_monitor.md
COUNT_EVENT_MONITOR -- requirements
Module: count_event_monitor

Interface
REQ-001 Parameter W, default 32, sets the width of the monitored count.
REQ-002 Parameter DEPTH, default 4, sets the number of event FIFO entries (power of 2, minimum 2).
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on the rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port count, input, W: up/down counter value, sampled every clk edge.
REQ-006 Port thresh_hi, input, W: upper crossing threshold.
REQ-007 Port thresh_lo, input, W: lower crossing threshold.
REQ-008 Port evt_ready, input, 1: consumer accepts the head event.
REQ-009 Port evt_valid, output, 1: FIFO is non-empty.
REQ-010 Port evt_code, output, 3: event code at the FIFO head.
REQ-011 Port evt_count, output, W: count value captured with the head event.
REQ-012 Port dir, output, 2: direction state (0 IDLE, 1 UP, 2 DOWN).
REQ-013 Port ovf, output, 1: sticky flag meaning an event was dropped.

Function
REQ-014 Registers prev holding the count from the prior edge; primed bit, clear after reset, set on the first edge; no event or dir update while primed=0.
REQ-015 Definition d = (count - prev) mod 2^W.
REQ-016 Definitions:
- up-step: d==1.
- down-step: d==2^W-1.
- hold: d==0 (no event).
- any other d: JUMP.
REQ-017 Definitions:
- WRAP_UP: prev==2^W-1 and count==0.
- WRAP_DN: prev==0 and count==2^W-1.
- Wraps are also up-/down-steps.
REQ-018 Direction FSM:
- IDLE -> UP on up-step; IDLE -> DOWN on down-step.
- UP -> DOWN on down-step, emitting DIR_DN.
- DOWN -> UP on up-step, emitting DIR_UP.
- JUMP returns to IDLE.
REQ-019 Threshold crossings, compared unsigned:
- CROSS_HI: prev<thresh_hi and count>=thresh_hi.
- CROSS_LO: prev>thresh_lo and count<=thresh_lo.
REQ-020 Codes: 1 WRAP_UP, 2 WRAP_DN, 3 DIR_UP, 4 DIR_DN, 5 CROSS_HI, 6 CROSS_LO, 7 JUMP; 0 unused.
REQ-021 At most one event per cycle, by priority JUMP > WRAP > DIR > CROSS_HI > CROSS_LO; lower-priority events that cycle are discarded silently, but FSM updates still occur.
REQ-022 An event detected at edge N is pushed at edge N as {code, count}; evt_valid is high after edge N (1-cycle latency).
REQ-023 Pop occurs on an edge where evt_valid && evt_ready; evt_code/evt_count hold stable while evt_valid && !evt_ready.
REQ-024 Push when full without a simultaneous pop drops the event and sets ovf, which stays set until rst.
REQ-025 Push and pop in the same cycle when full are both accepted; occupancy is unchanged.
REQ-026 Push and pop in the same cycle when empty cannot occur; evt_valid is registered from occupancy.

Reset
REQ-027 rst asynchronously clears:
- prev = 0, primed = 0, dir = IDLE.
- FIFO pointers and occupancy = 0.
- evt_valid = 0, evt_code = 0, evt_count = 0, ovf = 0.
REQ-028 rst asserted mid-operation discards all queued events; the first edge after release only primes.

Configuration
REQ-029 Macro COUNT_MON_STATS_EN, when defined, adds output drop_cnt (8 bits), reset 0, which increments on each dropped event and saturates at 255.
REQ-030 Without COUNT_MON_STATS_EN, drop_cnt and its logic are absent; all other behaviour is identical.

Structure
REQ-031 Shared package count_mon_pkg holds the event-code enum, the dir-state enum and the FIFO entry struct.
REQ-032 One sub-module, evt_fifo (synchronous, parameterised DEPTH, width 3+W), implements the queue; detection and the FSM live in the top.

Verification
REQ-033 Reset, then count 0,1,2,3 with evt_ready=1 -> no events; dir=UP after the second edge.
REQ-034 count 5,6,5 -> one DIR_DN entry with evt_count=5; dir=DOWN.
REQ-035 count FFFFFFFE, FFFFFFFF, 0 -> WRAP_UP with evt_count=0; then 0, FFFFFFFF -> WRAP_DN (wrap wins over DIR_DN); dir=DOWN.
REQ-036 thresh_hi=10, thresh_lo=3, count ramps 8..11 then down 11..2 -> CROSS_HI at 10; DIR_DN at 10; CROSS_LO at 3.
REQ-037 count 100 then 0 -> JUMP with evt_count=0; dir=IDLE.
REQ-038 evt_ready=0, generate 6 events with DEPTH=4 -> 4 queued in order, ovf=1, drop_cnt=2 (with STATS_EN); then evt_ready=1 with one simultaneous push at full -> occupancy stays 4.
